// File: rtl/haar_feature_sequencer.sv
// Sequences up to three rectangle-sum queries per Haar feature and accumulates the weighted sums.
// Optional HAAR_SEQ_TIMEOUT_EN aborts a feature whose rect sum never arrives within TIMEOUT cycles.
module haar_feature_sequencer #(
    parameter int SUM_WIDTH    = 24,
    parameter int WEIGHT_WIDTH = 4,
    parameter int ACC_WIDTH    = 32,
    parameter int TIMEOUT      = 15
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          feat_valid,
    output logic                          feat_ready,
    input  logic [1:0]                    feat_num_rects,
    input  logic [191:0]                  feat_rects,
    input  logic [3*WEIGHT_WIDTH-1:0]     feat_weights,
    input  logic signed [ACC_WIDTH-1:0]   feat_thresh,
    input  logic [15:0]                   win_x,
    input  logic [15:0]                   win_y,
    input  logic                          img_done,
    output logic [15:0]                   query_x1,
    output logic [15:0]                   query_y1,
    output logic [15:0]                   query_x2,
    output logic [15:0]                   query_y2,
    output logic                          query_valid,
    input  logic [SUM_WIDTH-1:0]          rect_sum,
    input  logic                          rect_sum_valid,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic signed [ACC_WIDTH-1:0]   res_sum,
    output logic                          res_pass,
    output logic                          res_error
);

    typedef enum logic [2:0] {IDLE, WAIT_IMG, ISSUE, WAIT_SUM, RESULT} state_t;

    state_t                        state, next_state;
    logic [1:0]                    idx;
    logic [ACC_WIDTH-1:0]          acc, acc_next;
    logic                          err, err_next;
    logic [1:0]                    num_q;
    logic [191:0]                  rects_q;
    logic [3*WEIGHT_WIDTH-1:0]     weights_q;
    logic signed [ACC_WIDTH-1:0]   thresh_q;
    logic [15:0]                   win_x_q, win_y_q;
    logic                          illegal, accept, issue, capture, last, load_res, timeout_hit;
    logic [63:0]                   rect_chk, cur_rect;
    logic [16:0]                   end_x, end_y;
    logic [ACC_WIDTH-1:0]          w_ext, s_ext;

    // A rect is legal only if ordered and its far corner still fits in 16 bits after the origin offset.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        illegal  = (feat_num_rects == 2'd0);
        rect_chk = '0;
        end_x    = '0;
        end_y    = '0;
        for (int i = 0; i < 3; i++) begin
            rect_chk = feat_rects[64*i +: 64];
            end_x    = {1'b0, rect_chk[31:16]} + {1'b0, win_x};
            end_y    = {1'b0, rect_chk[15:0]} + {1'b0, win_y};
            if (i < int'(feat_num_rects)) begin
                if (rect_chk[63:48] > rect_chk[31:16] || rect_chk[47:32] > rect_chk[15:0] ||
                    end_x[16] || end_y[16])
                    illegal = 1'b1;
            end
        end
    end

    assign cur_rect = rects_q[{idx, 6'd0} +: 64];
    assign w_ext    = {{(ACC_WIDTH-WEIGHT_WIDTH){weights_q[idx*WEIGHT_WIDTH + WEIGHT_WIDTH-1]}},
                       weights_q[idx*WEIGHT_WIDTH +: WEIGHT_WIDTH]};
    assign s_ext    = {{(ACC_WIDTH-SUM_WIDTH){1'b0}}, rect_sum};
    assign last     = (idx == num_q - 2'd1);

`ifdef HAAR_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] tcnt;

    assign timeout_hit = (state == WAIT_SUM) && !rect_sum_valid && (tcnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n)                tcnt <= '0;
        else if (issue)            tcnt <= '0;
        else if (state == WAIT_SUM) tcnt <= tcnt + 1'b1;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses non-blocking assignments.
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (feat_valid) next_state = illegal ? RESULT : (img_done ? ISSUE : WAIT_IMG);
            WAIT_IMG: if (img_done) next_state = ISSUE;
            ISSUE:    next_state = img_done ? WAIT_SUM : WAIT_IMG;
            WAIT_SUM: if (rect_sum_valid) next_state = last ? RESULT : ISSUE;
                      else if (timeout_hit) next_state = RESULT;
            RESULT:   if (res_valid && res_ready) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Output and datapath strobes
    always_comb begin
        feat_ready = (state == IDLE);
        accept     = feat_ready && feat_valid;
        issue      = (state == ISSUE) && img_done;
        capture    = (state == WAIT_SUM) && rect_sum_valid;
        load_res   = (next_state == RESULT) && (state != RESULT);
        acc_next   = acc;
        err_next   = err;
        if (accept) begin
            acc_next = '0;
            err_next = illegal;
        end else if (capture) begin
            acc_next = acc + w_ext * s_ext;
        end else if (timeout_hit) begin
            err_next = 1'b1;
        end
    end

    // NOTE: the latched feature fields are fully rewritten on accept, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            num_q     <= feat_num_rects;
            rects_q   <= feat_rects;
            weights_q <= feat_weights;
            thresh_q  <= feat_thresh;
            win_x_q   <= win_x;
            win_y_q   <= win_y;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx         <= '0;
            acc         <= '0;
            err         <= 1'b0;
            query_x1    <= '0;
            query_y1    <= '0;
            query_x2    <= '0;
            query_y2    <= '0;
            query_valid <= 1'b0;
            res_valid   <= 1'b0;
            res_sum     <= '0;
            res_pass    <= 1'b0;
            res_error   <= 1'b0;
        end else begin
            acc         <= acc_next;
            err         <= err_next;
            query_valid <= issue;
            if (accept)             idx <= '0;
            else if (capture && !last) idx <= idx + 2'd1;
            if (issue) begin
                query_x1 <= cur_rect[63:48] + win_x_q;
                query_y1 <= cur_rect[47:32] + win_y_q;
                query_x2 <= cur_rect[31:16] + win_x_q;
                query_y2 <= cur_rect[15:0]  + win_y_q;
            end
            // Result fields settle on RESULT entry; res_valid follows one cycle later.
            if (load_res) begin
                res_sum   <= acc_next;
                res_error <= err_next;
                res_pass  <= !err_next && ($signed(acc_next) >= thresh_q);
            end
            res_valid <= (state == RESULT) && !(res_valid && res_ready);
        end
    end

endmodule

// File: tb/tb_haar_feature_sequencer.sv
// Directed self-checking bench for haar_feature_sequencer; covers the timeout path when
// HAAR_SEQ_TIMEOUT_EN is defined and the wait-forever path otherwise.
module tb_haar_feature_sequencer;

    logic               clk;
    logic               rst_n;
    logic               feat_valid;
    logic               feat_ready;
    logic [1:0]         feat_num_rects;
    logic [191:0]       feat_rects;
    logic [11:0]        feat_weights;
    logic signed [31:0] feat_thresh;
    logic [15:0]        win_x, win_y;
    logic               img_done;
    logic [15:0]        query_x1, query_y1, query_x2, query_y2;
    logic               query_valid;
    logic [23:0]        rect_sum;
    logic               rect_sum_valid;
    logic               res_valid;
    logic               res_ready;
    logic signed [31:0] res_sum;
    logic               res_pass;
    logic               res_error;

    int n_cmp = 0;
    int n_err = 0;

    haar_feature_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .feat_valid(feat_valid), .feat_ready(feat_ready),
        .feat_num_rects(feat_num_rects), .feat_rects(feat_rects),
        .feat_weights(feat_weights), .feat_thresh(feat_thresh),
        .win_x(win_x), .win_y(win_y), .img_done(img_done),
        .query_x1(query_x1), .query_y1(query_y1), .query_x2(query_x2), .query_y2(query_y2),
        .query_valid(query_valid),
        .rect_sum(rect_sum), .rect_sum_valid(rect_sum_valid),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_pass(res_pass), .res_error(res_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rect(input int x1, input int y1, input int x2, input int y2);
        return {16'(x1), 16'(y1), 16'(x2), 16'(y2)};
    endfunction

    task automatic wait_query(input string tag);
        for (int k = 0; k < 20 && !query_valid; k++) tick;
        check(tag, query_valid, 1);
    endtask

    task automatic serve(input string tag, input int sum);
        wait_query(tag);
        rect_sum       = 24'(sum);
        rect_sum_valid = 1'b1;
        tick;
        rect_sum_valid = 1'b0;
    endtask

    task automatic wait_res(input string tag);
        for (int k = 0; k < 20 && !res_valid; k++) tick;
        check(tag, res_valid, 1);
    endtask

    task automatic handshake(input string tag);
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        check({tag, "_rv_low"}, res_valid, 0);
        check({tag, "_fr_high"}, feat_ready, 1);
    endtask

    task automatic accept;
        feat_valid = 1'b1;
        tick;
        feat_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; feat_valid = 1'b0; feat_num_rects = 2'd0; feat_rects = '0;
        feat_weights = '0; feat_thresh = '0; win_x = '0; win_y = '0; img_done = 1'b1;
        rect_sum = '0; rect_sum_valid = 1'b0; res_ready = 1'b0;
        tick; tick;
        check("rst_feat_ready", feat_ready, 1);
        check("rst_query_valid", query_valid, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_sum", res_sum, 0);
        rst_n = 1'b1;
        tick;

        // Two rects, origin (8,8), sums 160/40, exact latency checks
        feat_num_rects = 2'd2;
        feat_rects     = {64'd0, rect(4, 0, 7, 3), rect(0, 0, 3, 3)};
        feat_weights   = 12'h0F1;
        feat_thresh    = 100;
        win_x = 16'd8; win_y = 16'd8;
        accept;
        check("t1_fr_busy", feat_ready, 0);
        check("t1_no_query_e0", query_valid, 0);
        tick;
        check("t1_q0_valid", query_valid, 1);
        check("t1_q0", {query_x1, query_y1, query_x2, query_y2}, rect(8, 8, 11, 11));
        rect_sum = 24'd160; rect_sum_valid = 1'b1;
        tick;
        rect_sum_valid = 1'b0;
        check("t1_qv_pulse", query_valid, 0);
        check("t1_q_hold", query_x1, 8);
        tick;
        check("t1_q1_valid", query_valid, 1);
        check("t1_q1", {query_x1, query_y1, query_x2, query_y2}, rect(12, 8, 15, 11));
        rect_sum = 24'd40; rect_sum_valid = 1'b1;
        tick;
        rect_sum_valid = 1'b0;
        check("t1_rv_e4", res_valid, 0);
        tick;
        check("t1_rv_e5", res_valid, 1);
        check("t1_sum", res_sum, 120);
        check("t1_pass", res_pass, 1);
        check("t1_err", res_error, 0);
        feat_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick;
            check("t1_hold_rv", res_valid, 1);
            check("t1_hold_sum", res_sum, 120);
            check("t1_hold_fr", feat_ready, 0);
        end
        feat_valid = 1'b0;
        handshake("t1");

        // Three rects, weights +1/-2/+1, sums 50/30/20
        feat_num_rects = 2'd3;
        feat_rects     = {rect(4, 4, 5, 5), rect(2, 2, 3, 3), rect(0, 0, 1, 1)};
        feat_weights   = 12'h1E1;
        feat_thresh    = 0;
        win_x = 16'd0; win_y = 16'd0;
        accept;
        serve("t2_q0", 50); serve("t2_q1", 30); serve("t2_q2", 20);
        wait_res("t2_rv");
        check("t2_sum", res_sum, 10);
        check("t2_pass", res_pass, 1);
        handshake("t2");
        feat_thresh = 11;
        accept;
        serve("t3_q0", 50); serve("t3_q1", 30); serve("t3_q2", 20);
        wait_res("t3_rv");
        check("t3_sum", res_sum, 10);
        check("t3_pass", res_pass, 0);
        handshake("t3");

        // img_done low at accept; unused rect 1 is illegal but must be ignored; sum equals thresh
        feat_num_rects = 2'd1;
        feat_rects     = {64'd0, rect(9, 0, 1, 0), rect(1, 2, 3, 4)};
        feat_weights   = 12'h003;
        feat_thresh    = 21;
        win_x = 16'd100; win_y = 16'd200;
        img_done = 1'b0;
        accept;
        for (int k = 0; k < 6; k++) begin
            check("t4_no_query", query_valid, 0);
            tick;
        end
        img_done = 1'b1;
        wait_query("t4_q");
        check("t4_coords", {query_x1, query_y1, query_x2, query_y2}, rect(101, 202, 103, 204));
        serve("t4_serve", 7);
        wait_res("t4_rv");
        check("t4_sum", res_sum, 21);
        check("t4_pass", res_pass, 1);
        check("t4_err", res_error, 0);
        handshake("t4");

        // Illegal features: zero rects, x1>x2, offset overflow
        feat_thresh = -50;
        win_x = 16'd0; win_y = 16'd0;
        feat_num_rects = 2'd0;
        feat_rects     = {128'd0, rect(0, 0, 3, 3)};
        accept;
        check("t5_no_query", query_valid, 0);
        tick;
        check("t5_rv", res_valid, 1);
        check("t5_err", res_error, 1);
        check("t5_sum", res_sum, 0);
        check("t5_pass", res_pass, 0);
        check("t5_no_query2", query_valid, 0);
        handshake("t5");
        feat_num_rects = 2'd1;
        feat_rects     = {128'd0, rect(5, 0, 4, 3)};
        accept;
        tick;
        check("t6_rv", res_valid, 1);
        check("t6_err", res_error, 1);
        check("t6_pass", res_pass, 0);
        check("t6_no_query", query_valid, 0);
        handshake("t6");
        feat_rects = {128'd0, rect(0, 0, 16'hFFF0, 3)};
        win_x      = 16'h0020;
        accept;
        tick;
        check("t7_err", res_error, 1);
        check("t7_no_query", query_valid, 0);
        handshake("t7");

        // Withheld rect sum
        feat_rects   = {128'd0, rect(1, 1, 2, 2)};
        win_x        = 16'd0;
        feat_weights = 12'h001;
        feat_thresh  = 0;
        accept;
        wait_query("t8_q");
`ifdef HAAR_SEQ_TIMEOUT_EN
        for (int k = 0; k < 14; k++) tick;
        check("t8_err_early", res_error, 0);
        tick;
        check("t8_err_15", res_error, 1);
        check("t8_sum", res_sum, 0);
        check("t8_pass", res_pass, 0);
        tick;
        check("t8_rv", res_valid, 1);
        handshake("t8");
        accept;
        wait_query("t9_q");
`else
        for (int k = 0; k < 30; k++) tick;
        check("t8_no_res", res_valid, 0);
        check("t8_busy", feat_ready, 0);
`endif

        // Reset during WAIT_SUM, then a late sum strobe
        rst_n = 1'b0;
        tick;
        check("t9_fr", feat_ready, 1);
        check("t9_qv", query_valid, 0);
        check("t9_rv", res_valid, 0);
        check("t9_err", res_error, 0);
        check("t9_pass", res_pass, 0);
        check("t9_sum", res_sum, 0);
        check("t9_query", {query_x1, query_y1, query_x2, query_y2}, 64'd0);
        rst_n = 1'b1;
        rect_sum = 24'd99; rect_sum_valid = 1'b1;
        tick;
        rect_sum_valid = 1'b0;
        tick; tick;
        check("t9_late_rv", res_valid, 0);
        check("t9_late_fr", feat_ready, 1);
        check("t9_late_qv", query_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
